// File: rtl/dig_pkg.sv
// Shared definitions for the BCD display feeder: FSM states, default store
// addresses, saturation limit and conversion length.
`default_nettype none

package dig_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [31:0] DEF_RAW_ADDR = 32'hFFFF_F000;
    localparam logic [31:0] DEF_DEC_ADDR = 32'hFFFF_F004;
    localparam logic [31:0] BCD_MAX      = 32'd99_999_999;
    localparam logic [5:0]  CONV_CYCLES  = 6'd32;

    // Eight BCD digits cannot show more than BCD_MAX.
    function automatic logic [31:0] clamp_operand(input logic [31:0] v, input logic sat);
        return (sat && (v > BCD_MAX)) ? BCD_MAX : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dig_bcd_feeder_if.sv
// CPU store bus in, display write port out, grouped for the BCD feeder.
`default_nettype none

interface dig_bcd_feeder_if;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [31:0] dig_addr;
    logic        dig_we;
    logic [31:0] dig_wdata;
    logic        busy;

    modport master (
        output bus_addr, bus_we, bus_wdata,
        input  dig_addr, dig_we, dig_wdata, busy
    );

    modport slave (
        input  bus_addr, bus_we, bus_wdata,
        output dig_addr, dig_we, dig_wdata, busy
    );
endinterface

`default_nettype wire

// File: rtl/dig_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift in one bit.
`default_nettype none

module dig_dabble_step (
    input  wire logic [31:0] acc_i,
    input  wire logic        bit_i,
    output logic      [31:0] acc_o
);
    logic [31:0] w_adj;

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_digit
            assign w_adj[4*g +: 4] = (acc_i[4*g +: 4] >= 4'd5) ? (acc_i[4*g +: 4] + 4'd3)
                                                              : acc_i[4*g +: 4];
        end
    endgenerate

    // Bit 31 of the adjusted value is the carry out of digit 7 and is dropped.
    assign acc_o = {w_adj[30:0], bit_i};

endmodule

`default_nettype wire

// File: rtl/dig_bcd_feeder.sv
// Forwards raw stores to a hex display, or converts decimal stores to packed BCD
// over 32 shift cycles before writing them out.
`default_nettype none

module dig_bcd_feeder
    import dig_pkg::*;
#(
    parameter logic [31:0] RAW_ADDR = DEF_RAW_ADDR,
    parameter logic [31:0] DEC_ADDR = DEF_DEC_ADDR,
    parameter int          SAT      = 1
) (
    input  wire logic          bcd_clk,
    input  wire logic          bcd_rst,
    dig_bcd_feeder_if.slave    bus
);
    state_t      state_q, state_d;
    logic [5:0]  cnt_q,   cnt_d;
    logic [31:0] acc_q,   acc_d;
    logic [31:0] op_q,    op_d;
    logic        dig_we_q,    dig_we_d;
    logic [31:0] dig_wdata_q, dig_wdata_d;

    logic        w_raw_hit;
    logic        w_dec_hit;
    logic [31:0] w_step;

    assign w_raw_hit = bus.bus_we && (bus.bus_addr == RAW_ADDR);
    assign w_dec_hit = bus.bus_we && (bus.bus_addr == DEC_ADDR);

    dig_dabble_step u_step (
        .acc_i (acc_q),
        .bit_i (op_q[31]),
        .acc_o (w_step)
    );

    always_ff @(posedge bcd_clk) begin
        if (bcd_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            op_q        <= '0;
            dig_we_q    <= 1'b0;
            dig_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            dig_we_q    <= dig_we_d;
            dig_wdata_q <= dig_wdata_d;
        end
    end

    // A new accepted store always overrides whatever the conversion was doing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        op_d        = op_q;
        dig_we_d    = 1'b0;
        dig_wdata_d = dig_wdata_q;

        if (w_raw_hit) begin
            state_d     = IDLE;
            cnt_d       = '0;
            dig_we_d    = 1'b1;
            dig_wdata_d = bus.bus_wdata;
        end else if (w_dec_hit) begin
            state_d = SHIFT;
            cnt_d   = CONV_CYCLES;
            acc_d   = '0;
            op_d    = clamp_operand(bus.bus_wdata, SAT != 0);
        end else if (state_q == SHIFT) begin
            acc_d = w_step;
            op_d  = {op_q[30:0], 1'b0};
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
                state_d     = IDLE;
                dig_we_d    = 1'b1;
                dig_wdata_d = w_step;
            end
        end
    end

    assign bus.dig_we    = dig_we_q;
    assign bus.dig_wdata = dig_wdata_q;
    assign bus.dig_addr  = dig_we_q ? RAW_ADDR : '0;
    assign bus.busy      = (state_q == SHIFT);

endmodule

`default_nettype wire
